// File: rtl/pe_post_sched.sv
// Round-robin scheduler sharing one post-processing lane (ReLU, rounding shift,
// saturation) among N accumulator outputs, behind a two-stage valid/ready pipeline.
module pe_post_sched #(
  parameter int N   = 4,
  parameter int W   = 24,
  parameter int OW  = 8,
  parameter int SHW = 5,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_relu_en,
  input  logic [SHW-1:0]       cfg_shift,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [OW-1:0]        out_data,
  output logic [SW-1:0]        out_src,
  input  logic                 out_ready,
  output logic                 idle
);

  localparam int OMAXI = (1 << (OW - 1)) - 1;
  localparam logic signed [W:0] OMAX = (W + 1)'(OMAXI);
  localparam logic signed [W:0] OMIN = (W + 1)'(-OMAXI - 1);

  logic [W-1:0]   req_arr [N];
  logic [SW-1:0]  ptr;
  logic [SW-1:0]  grant;
  logic [SW-1:0]  ptr_nxt;
  logic           found;
  logic           accept;
  logic [SHW-1:0] shift_cl;

  logic                s1_valid;
  logic signed [W-1:0] s1_data;
  logic [SW-1:0]       s1_src;
  logic                s1_relu;
  logic [SHW-1:0]      s1_shift;
  logic                s2_valid;
  logic                s1_can_load;
  logic                s2_can_load;

  logic signed [W-1:0] x;
  logic signed [W:0]   xe;
  logic signed [W:0]   rnd;
  logic signed [W:0]   y;
  logic [OW-1:0]       sat;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign req_arr[g] = req_data[g*W +: W];
  end

  // Priority search starting at ptr, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % 32'(N);
      if (!found && req_valid[SW'(idx)]) begin
        found = 1'b1;
        grant = SW'(idx);
      end
    end
  end

  assign s2_can_load = !s2_valid || out_ready;
  assign s1_can_load = !s1_valid || s2_can_load;
  assign accept      = found && s1_can_load && !rst;
  assign req_ready   = accept ? (N'(1) << grant) : '0;
  assign ptr_nxt     = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
  assign shift_cl    = ({{(32-SHW){1'b0}}, cfg_shift} >= 32'(W)) ? SHW'(W - 1) : cfg_shift;

  // Rounding add done one bit wider than the data so 2^(shift-1) cannot overflow.
  always_comb begin
    x = s1_data;
    if (s1_relu && x[W-1]) x = '0;
    xe  = {x[W-1], x};
    rnd = '0;
    y   = xe;
    if (s1_shift != '0) begin
      rnd = (W + 1)'(1) << (s1_shift - 1'b1);
      y   = (xe + rnd) >>> s1_shift;
    end
    if (y > OMAX)      sat = {1'b0, {(OW-1){1'b1}}};
    else if (y < OMIN) sat = {1'b1, {(OW-1){1'b0}}};
    else               sat = y[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_src   <= '0;
      s1_relu  <= 1'b0;
      s1_shift <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      if (s1_valid && s2_can_load) begin
        s2_valid <= 1'b1;
        out_data <= sat;
        out_src  <= s1_src;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
      if (s1_can_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data  <= req_arr[grant];
          s1_src   <= grant;
          s1_relu  <= cfg_relu_en;
          s1_shift <= shift_cl;
        end
      end
      if (accept) ptr <= ptr_nxt;
    end
  end

  assign out_valid = s2_valid;
  // Reported idle while rst is held even if requesters are asserting valid.
  assign idle = !s1_valid && !s2_valid && (rst || (req_valid == '0));

endmodule

// File: tb/tb_pe_post_sched.sv
// Randomized bench for pe_post_sched against a queue-based model of in-flight beats.
module tb_pe_post_sched;
  localparam int N = 4, W = 24, OW = 8, SHW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_relu_en;
  logic [SHW-1:0]   cfg_shift;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [OW-1:0]    out_data;
  logic [1:0]       out_src;
  logic             out_ready;
  logic             idle;

  always #5 clk = ~clk;

  pe_post_sched #(.N(N), .W(W), .OW(OW), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .cfg_relu_en(cfg_relu_en), .cfg_shift(cfg_shift),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .idle(idle)
  );

  typedef struct {int data; int src; int acc;} beat_t;
  beat_t q[$];
  int    ptr_m, cyc, checks, errors, exp_val;
  bit    m_acc, use_exp;

  function automatic int ref_post(int xin, bit relu, int sh);
    longint v;
    v = xin;
    if (sh >= W) sh = W - 1;
    if (relu && v < 0) v = 0;
    if (sh > 0) v = (v + (64'sd1 <<< (sh - 1))) >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  function automatic int lane(int i);
    logic signed [W-1:0] d;
    d = req_data[i*W +: W];
    return int'(d);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    int g;
    bit found, vis;
    logic [N-1:0] er;
    beat_t b;
    @(negedge clk);
    found = 0;
    g = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr_m + k) % N;
      if (!found && req_valid[j]) begin
        found = 1;
        g = j;
      end
    end
    er = '0;
    if (!rst && found && (q.size() < 2 || out_ready)) er[g] = 1'b1;
    vis = (q.size() > 0) && (cyc >= q[0].acc + 2);
    chk("req_ready", {28'd0, req_ready}, {28'd0, er});
    chk("out_valid", {31'd0, out_valid}, {31'd0, vis});
    if (vis) begin
      chk("out_data", $signed(out_data), q[0].data);
      chk("out_src", {30'd0, out_src}, q[0].src);
    end
    chk("idle", {31'd0, idle}, {31'd0, (q.size() == 0 && (rst || req_valid == '0))});
    m_acc = 0;
    if (rst) begin
      q.delete();
      ptr_m = 0;
    end else begin
      if (vis && out_ready) void'(q.pop_front());
      if (er != '0) begin
        b.data = use_exp ? exp_val : ref_post(lane(g), cfg_relu_en, int'(cfg_shift));
        b.src  = g;
        b.acc  = cyc;
        q.push_back(b);
        ptr_m = (g + 1) % N;
        m_acc = 1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  int dv[7]  = '{291, -100, -100, 5000, -5000, 24, 8388607};
  bit dr[7]  = '{0, 1, 0, 0, 0, 0, 0};
  int ds[7]  = '{4, 4, 4, 0, 0, 4, 31};
  int de[7]  = '{18, 0, -6, 127, -128, 2, 1};

  initial begin
    int v;
    checks = 0; errors = 0; cyc = 0; ptr_m = 0; use_exp = 0; exp_val = 0;
    rst = 1'b1; req_valid = '1; req_data = '0; cfg_relu_en = 1'b0;
    cfg_shift = SHW'(4); out_ready = 1'b1;
    rand_data();
    @(posedge clk);
    #1;
    repeat (2) step();
    rst = 1'b0;

    // all requesters valid: strict rotation, one result per cycle
    repeat (12) begin rand_data(); step(); end

    // directed arithmetic on a single requester
    req_valid = 4'b0001;
    use_exp = 1;
    for (int i = 0; i < 7; i++) begin
      req_data[0 +: W] = W'(dv[i]);
      cfg_relu_en = dr[i];
      cfg_shift = SHW'(ds[i]);
      exp_val = de[i];
      step();
    end
    use_exp = 0;
    cfg_relu_en = 1'b0;
    cfg_shift = SHW'(4);

    req_valid = 4'b1010;
    repeat (8) begin rand_data(); step(); end

    // backpressure stream 1..6 from requester 2
    req_valid = 4'b0100;
    cfg_shift = '0;
    v = 1;
    for (int c = 0; c < 40 && v <= 6; c++) begin
      req_data[2*W +: W] = W'(v);
      out_ready = !(c >= 3 && c <= 5);
      step();
      if (m_acc) v++;
    end
    chk("bp_sent", v, 7);
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) step();

    // config isolation: relu toggles every cycle while streaming -50
    req_valid = 4'b0001;
    req_data[0 +: W] = W'(-50);
    repeat (10) begin cfg_relu_en = ~cfg_relu_en; step(); end

    repeat (300) begin
      req_valid = N'($urandom);
      rand_data();
      cfg_relu_en = 1'($urandom);
      cfg_shift = SHW'($urandom);
      out_ready = ($urandom % 4) != 0;
      step();
    end

    // mid-flight reset with two beats held
    req_valid = '0;
    out_ready = 1'b1;
    repeat (3) step();
    req_valid = '1;
    out_ready = 1'b0;
    rand_data();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin rand_data(); step(); end

    req_valid = '0;
    repeat (4) step();
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
